// File: rtl/pc_register.sv
// pc_register: SEQ Y86-64 PC/status register with retired-instruction counter.
// Optional `PC_TRACE_EN adds prev_pc, the PC of the last retired instruction.
module pc_register #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      updated_pc,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             stall,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic             halted,
`ifdef PC_TRACE_EN
  output logic [63:0]      prev_pc,
`endif
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {RUN = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4} state_t;
  state_t state;
  // State encoding equals the architectural stat code, so stat is the register itself.
  assign stat   = state;
  assign halted = state != RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RUN;
      PC          <= RESET_PC;
      instr_count <= '0;
`ifdef PC_TRACE_EN
      prev_pc     <= RESET_PC;
`endif
    end else if (state == RUN && !stall) begin
      if (imem_error || dmem_error) state <= S_ADR;
      else if (!instr_valid) state <= S_INS;
      else begin
        if (icode == 4'h0) state <= S_HLT;
        else PC <= updated_pc;
        if (~&instr_count) instr_count <= instr_count + 1'b1;
`ifdef PC_TRACE_EN
        prev_pc <= PC;
`endif
      end
    end
endmodule

// File: tb/tb_pc_register.sv
// tb_pc_register: directed plus random stimulus against a retire-count reference model.
module tb_pc_register;
  localparam logic [63:0] RP = 64'h100;
  logic clk = 0, rst_n = 1;
  logic [63:0] updated_pc = 0;
  logic [3:0] icode = 6;
  logic instr_valid = 1, imem_error = 0, dmem_error = 0, stall = 0;
  logic [63:0] pc, pc2;
  logic [2:0] stat, stat2;
  logic halted, halted2;
  logic [31:0] cnt;
  logic [1:0] cnt2;
`ifdef PC_TRACE_EN
  logic [63:0] prev, prev2;
`endif
  logic [63:0] m_pc, m_prev;
  int m_stat;
  longint m_cnt;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  pc_register #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n), .updated_pc(updated_pc), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .stall(stall), .PC(pc), .stat(stat), .halted(halted),
`ifdef PC_TRACE_EN
    .prev_pc(prev),
`endif
    .instr_count(cnt));

  pc_register #(.RESET_PC(RP), .CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .updated_pc(updated_pc), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .stall(stall), .PC(pc2), .stat(stat2), .halted(halted2),
`ifdef PC_TRACE_EN
    .prev_pc(prev2),
`endif
    .instr_count(cnt2));

  task automatic model_reset();
    m_pc = RP; m_prev = RP; m_stat = 1; m_cnt = 0;
  endtask

  // Architectural view: an instruction either retires, faults, or nothing happens.
  task automatic model_edge();
    if (m_stat == 1 && !stall) begin
      if (imem_error || dmem_error) m_stat = 3;
      else if (!instr_valid) m_stat = 4;
      else begin
        m_cnt++;
        m_prev = m_pc;
        if (icode == 4'h0) m_stat = 2;
        else m_pc = updated_pc;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [1:0] exp2;
    exp2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    vectors++;
    assert (pc === m_pc) else begin miscompares++; $error("FAIL %s PC got %h exp %h", tag, pc, m_pc); end
    vectors++;
    assert (stat === 3'(m_stat)) else begin miscompares++; $error("FAIL %s stat got %0d exp %0d", tag, stat, m_stat); end
    vectors++;
    assert (halted === (m_stat != 1)) else begin miscompares++; $error("FAIL %s halted got %b exp %b", tag, halted, m_stat != 1); end
    vectors++;
    assert (cnt === 32'(m_cnt)) else begin miscompares++; $error("FAIL %s count got %0d exp %0d", tag, cnt, m_cnt); end
    vectors++;
    assert (cnt2 === exp2 && pc2 === m_pc) else begin miscompares++; $error("FAIL %s sat count got %0d exp %0d", tag, cnt2, exp2); end
`ifdef PC_TRACE_EN
    vectors++;
    assert (prev === m_prev) else begin miscompares++; $error("FAIL %s prev_pc got %h exp %h", tag, prev, m_prev); end
`endif
  endtask

  task automatic set(input logic [63:0] u, input logic [3:0] ic, input logic v, ie, de, st);
    updated_pc = u; icode = ic; instr_valid = v; imem_error = ie; dmem_error = de; stall = st;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1 check(tag);
  endtask

  // Asynchronous reset: checked with no clock edge in between.
  task automatic do_reset(input string tag);
    rst_n = 1;
    #1 rst_n = 0;
    #1 model_reset();
    check(tag);
    #1 rst_n = 1;
  endtask

  initial begin
    do_reset("t1_reset");
    set(64'h0A, 6, 1, 0, 0, 0); cyc("t2_seq0");
    set(64'h14, 6, 1, 0, 0, 0); cyc("t2_seq1");
    set(64'h1E, 6, 1, 0, 0, 0); cyc("t2_seq2");
    set(64'h99, 0, 1, 0, 0, 0); cyc("t3_halt");
    set(64'h55, 6, 1, 1, 1, 0); cyc("t3_ignore0");
    set(64'h66, 6, 0, 0, 0, 0); cyc("t3_ignore1");
    @(negedge clk); do_reset("t7_async");
    set(64'h40, 6, 1, 0, 0, 0); cyc("t8_pc40");
    set(64'h80, 6, 1, 0, 0, 0); cyc("t8_pc80");
    set(64'h90, 6, 0, 0, 1, 0); cyc("t4_prio");
    do_reset("rst_a");
    set(64'h90, 6, 0, 0, 0, 0); cyc("t5_invalid");
    do_reset("rst_b");
    set(64'h90, 'x, 'x, 1, 0, 1); cyc("t6_stall0");
    set(64'h90, 6, 1, 1, 0, 1); cyc("t6_stall1");
    set(64'h90, 6, 1, 1, 0, 0); cyc("t6_release");
    do_reset("rst_c");
    set(64'hFFFF_FFFF_FFFF_FFF0, 6, 1, 0, 0, 0); cyc("wrap_hi");
    set(64'h0, 6, 1, 0, 0, 0); cyc("wrap_zero");
    for (int i = 0; i < 400; i++) begin
      if (m_stat != 1 && $urandom_range(0, 3) == 0) do_reset("rnd_reset");
      set({$urandom, $urandom},
          ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
          $urandom_range(0, 24) != 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      if (stall && $urandom_range(0, 1) == 0) begin icode = 'x; instr_valid = 'x; end
      cyc("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
